button_bank: RTL and testbench
==============================

BUTTON_BANK -- requirements
Module: button_bank

Interface
REQ-001 SHALL have parameter CHANNELS, default 5, number of independent input channels.
REQ-002 SHALL have parameter STABLE_CYCLES, default 650000, number of consecutive cycles a changed level must persist before it is accepted (>=1).
REQ-003 SHALL have parameter REPEAT_DELAY, default 32500000, cycles from accepted press to the first auto-repeat strobe (>=1).
REQ-004 SHALL have parameter REPEAT_PERIOD, default 6500000, cycles between later auto-repeat strobes (>=1).
REQ-005 SHALL have parameter CNT_W, default 25, width of every internal counter; every cycle parameter SHALL be < 2^CNT_W.
REQ-006 SHALL have port clock, input, 1, the single clock; all logic on its rising edge.
REQ-007 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-008 SHALL have port noisy, input, CHANNELS, raw asynchronous button/switch levels.
REQ-009 SHALL have port repeat_en, input, CHANNELS, per-channel auto-repeat enable.
REQ-010 SHALL have port clean, output, CHANNELS, debounced level.
REQ-011 SHALL have port rise, output, CHANNELS, one-cycle pulse on an accepted 0->1 change.
REQ-012 SHALL have port fall, output, CHANNELS, one-cycle pulse on an accepted 1->0 change.
REQ-013 SHALL have port press, output, CHANNELS, one-cycle strobe equal to rise OR the auto-repeat strobe.

Function
REQ-014 SHALL pass each noisy bit through a two-flop synchronizer; sync[i] is the second flop.
REQ-015 SHALL, each cycle where sync[i]==clean[i], clear counter cnt[i] to 0.
REQ-016 SHALL, each cycle where sync[i]!=clean[i] and cnt[i]<STABLE_CYCLES-1, increment cnt[i].
REQ-017 SHALL, each cycle where sync[i]!=clean[i] and cnt[i]==STABLE_CYCLES-1, load clean[i]<=sync[i] and clear cnt[i].
REQ-018 SHALL, as a consequence of REQ-014..017, change clean on the (STABLE_CYCLES+2)th rising edge, counting the first edge at which the new noisy level is sampled as edge 1; any glitch back to the old level restarts the count.
REQ-019 SHALL register rise/fall on the same edge as the clean update, high for exactly one cycle.
REQ-020 SHALL implement per-channel repeat FSM states IDLE, DELAY, REPEAT, with timer tmr[i] (CNT_W bits).
REQ-021 SHALL, in IDLE, go to DELAY with tmr=0 on the edge that asserts rise[i] while repeat_en[i]=1.
REQ-022 SHALL, in DELAY, increment tmr each cycle; when tmr==REPEAT_DELAY-1, assert repeat strobe for one cycle, go to REPEAT, tmr<=0.
REQ-023 SHALL, in REPEAT, increment tmr each cycle; when tmr==REPEAT_PERIOD-1, assert repeat strobe for one cycle, tmr<=0.
REQ-024 SHALL, from DELAY or REPEAT, return to IDLE with tmr=0 on the edge that asserts fall[i] or on any cycle where repeat_en[i]=0.
REQ-025 SHALL give return-to-IDLE priority over timer expiry in the same cycle: no repeat strobe is issued that cycle.
REQ-026 SHALL keep channels fully independent; simultaneous events on different channels SHALL be handled in the same cycle.
REQ-027 SHALL register press so that it asserts on the same edge as the rise or repeat strobe that causes it.

Reset
REQ-028 SHALL, on reset, clear synchronizer flops, clean, rise, fall, press, all cnt and tmr, and force every FSM to IDLE.
REQ-029 SHALL, if reset is asserted mid-count or mid-repeat, abandon that operation with no pulse issued.
REQ-030 SHALL, if noisy is held high through reset release, treat it as a new press: clean, rise and press assert on edge STABLE_CYCLES+2 after release.

Verification (CHANNELS=2, STABLE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
REQ-031 Clean press: noisy[0] 0->1 sampled at edge 1, repeat_en=0 -> clean[0]=1, rise[0]=press[0]=1 on edge 6 only; no further press.
REQ-032 Glitch: noisy[0] high for 3 cycles then low -> clean, rise, press stay 0 throughout.
REQ-033 Auto-repeat: repeat_en[0]=1, press as in REQ-031, held -> press[0] at edges 6, 16, 19, 22, ...
REQ-034 Release race: release timed so fall[0] lands on the same edge as a repeat expiry -> fall[0]=1, press[0]=0 that edge, FSM IDLE.
REQ-035 Reset mid-repeat: reset at edge 17 for 1 cycle with noisy held -> all outputs 0, then clean/rise/press again 6 edges after release.
REQ-036 Independence: channel 1 pressed 2 cycles after channel 0 -> rise[1] exactly 2 edges after rise[0]; channel 0 timing unchanged.

Source files
------------

// File: rtl/button_bank.sv
// button_bank: per-channel debounce with rise/fall pulses and auto-repeat press strobes
module button_bank #(
  parameter int CHANNELS      = 5,
  parameter int STABLE_CYCLES = 650000,
  parameter int REPEAT_DELAY  = 32500000,
  parameter int REPEAT_PERIOD = 6500000,
  parameter int CNT_W         = 25
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] noisy,
  input  logic [CHANNELS-1:0] repeat_en,
  output logic [CHANNELS-1:0] clean,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] press
);
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;
  localparam logic [CNT_W-1:0] STABLE_MAX = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_MAX  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_MAX = CNT_W'(REPEAT_PERIOD - 1);
  logic [CHANNELS-1:0] meta, sync;
  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= '0;
      sync <= '0;
    end else begin
      meta <= noisy;
      sync <= meta;
    end
  end
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [CNT_W-1:0] cnt, tmr, tmr_next;
    state_t state, state_next;
    logic clean_q, rise_q, fall_q, press_q;
    logic accept, rise_next, fall_next, leave, rep;
    assign accept    = (sync[i] != clean_q) && (cnt == STABLE_MAX);
    assign rise_next = accept && sync[i];
    assign fall_next = accept && !sync[i];
    // dropping out of repeat wins over a timer expiry in the same cycle
    assign leave     = fall_next || !repeat_en[i];
    always_comb begin
      state_next = state;
      tmr_next   = '0;
      rep        = 1'b0;
      case (state)
        IDLE: state_next = (rise_next && repeat_en[i]) ? DELAY : IDLE;
        DELAY, REPEAT: begin
          rep        = !leave && (tmr == ((state == DELAY) ? DELAY_MAX : PERIOD_MAX));
          state_next = leave ? IDLE : rep ? REPEAT : state;
          tmr_next   = (leave || rep) ? '0 : tmr + 1'b1;
        end
        default: state_next = IDLE;
      endcase
    end
    always_ff @(posedge clock) begin
      if (reset) begin
        cnt     <= '0;
        clean_q <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
        press_q <= 1'b0;
        state   <= IDLE;
        tmr     <= '0;
      end else begin
        cnt     <= (sync[i] == clean_q || accept) ? '0 : cnt + 1'b1;
        clean_q <= accept ? sync[i] : clean_q;
        rise_q  <= rise_next;
        fall_q  <= fall_next;
        press_q <= rise_next || rep;
        state   <= state_next;
        tmr     <= tmr_next;
      end
    end
    assign clean[i] = clean_q;
    assign rise[i]  = rise_q;
    assign fall[i]  = fall_q;
    assign press[i] = press_q;
  end
endmodule

// File: tb/tb_button_bank.sv
// tb_button_bank: directed and randomized checks of button_bank against a window/timestamp model
module tb_button_bank;
  localparam int S = 4;
  localparam int D = 10;
  localparam int P = 3;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [1:0] noisy = '0;
  logic [1:0] repeat_en = '0;
  logic [1:0] clean, rise, fall, press;
  int errors = 0;
  int checks = 0;
  int t = 0;
  bit mclean[2], mrise[2], mfall[2], mpress[2], m1[2], m2[2], active[2];
  int start[2];
  bit hist[2][$];
  button_bank #(.CHANNELS(2), .STABLE_CYCLES(S), .REPEAT_DELAY(D), .REPEAT_PERIOD(P), .CNT_W(8)) dut (
    .clock(clock), .reset(reset), .noisy(noisy), .repeat_en(repeat_en),
    .clean(clean), .rise(rise), .fall(fall), .press(press)
  );
  always #5 clock = ~clock;
  // clean flips once the last S synchronized samples all disagree with it;
  // repeat strobes fall at fixed offsets D, D+P, D+2P... from the accepted press
  task automatic model_edge();
    bit flip, strobe, leave;
    int k;
    t++;
    for (int c = 0; c < 2; c++) begin
      if (reset) begin
        mclean[c] = 0; mrise[c] = 0; mfall[c] = 0; mpress[c] = 0;
        m1[c] = 0; m2[c] = 0; active[c] = 0;
        hist[c].delete();
        repeat (S) hist[c].push_back(1'b0);
      end else begin
        flip = 1;
        for (int j = 0; j < S; j++) if (hist[c][j] == mclean[c]) flip = 0;
        mrise[c] = flip && !mclean[c];
        mfall[c] = flip && mclean[c];
        mclean[c] = mclean[c] ^ flip;
        leave = mfall[c] || !repeat_en[c];
        k = t - start[c];
        strobe = active[c] && !leave && (k == D || (k > D && (k - D) % P == 0));
        if (leave) active[c] = 0;
        if (mrise[c] && repeat_en[c]) begin active[c] = 1; start[c] = t; end
        mpress[c] = mrise[c] || strobe;
        m2[c] = m1[c];
        m1[c] = noisy[c];
        hist[c].push_back(m2[c]);
        void'(hist[c].pop_front());
      end
    end
  endtask
  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
  endtask
  function automatic logic [7:0] dut_v();
    return {clean, rise, fall, press};
  endfunction
  function automatic logic [7:0] exp_v();
    return {mclean[1], mclean[0], mrise[1], mrise[0], mfall[1], mfall[0], mpress[1], mpress[0]};
  endfunction
  task automatic reset_dut();
    reset = 1; noisy = '0; repeat_en = '0;
    repeat (2) step();
    reset = 0;
    repeat (3) step();
  endtask
  task automatic test_reset();
    reset = 1; noisy = 2'b11; repeat_en = 2'b11;
    repeat (3) begin
      step();
      checks++;
      if (dut_v() !== 8'h00) begin errors++; $display("FAIL reset got=%h exp=00", dut_v()); end
    end
    reset_dut();
  endtask
  task automatic test_clean_press();
    reset_dut();
    noisy[0] = 1;
    for (int e = 1; e <= 12; e++) begin
      step();
      checks++;
      if (dut_v() !== exp_v()) begin errors++; $display("FAIL clean_press_model e=%0d got=%h exp=%h", e, dut_v(), exp_v()); end
      checks++;
      if ({clean[0], rise[0], press[0]} !== ((e == 6) ? 3'b111 : (e > 6) ? 3'b100 : 3'b000)) begin
        errors++; $display("FAIL clean_press e=%0d got=%b", e, {clean[0], rise[0], press[0]});
      end
    end
  endtask
  task automatic test_glitch();
    reset_dut();
    for (int e = 1; e <= 14; e++) begin
      noisy[0] = (e <= 3);
      step();
      checks++;
      if (dut_v() !== exp_v()) begin errors++; $display("FAIL glitch_model e=%0d got=%h exp=%h", e, dut_v(), exp_v()); end
      checks++;
      if ({clean[0], rise[0], press[0]} !== 3'b000) begin errors++; $display("FAIL glitch e=%0d got=%b exp=000", e, {clean[0], rise[0], press[0]}); end
    end
  endtask
  task automatic test_auto_repeat();
    int got[$];
    int want[5] = '{6, 16, 19, 22, 25};
    reset_dut();
    repeat_en[0] = 1; noisy[0] = 1;
    for (int e = 1; e <= 26; e++) begin
      step();
      if (press[0]) got.push_back(e);
      checks++;
      if (dut_v() !== exp_v()) begin errors++; $display("FAIL auto_repeat_model e=%0d got=%h exp=%h", e, dut_v(), exp_v()); end
    end
    checks++;
    if (got.size() != 5) begin errors++; $display("FAIL auto_repeat_count got=%0d exp=5", got.size()); end
    else for (int i = 0; i < 5; i++) begin
      checks++;
      if (got[i] != want[i]) begin errors++; $display("FAIL auto_repeat_edge i=%0d got=%0d exp=%0d", i, got[i], want[i]); end
    end
  endtask
  task automatic test_release_race();
    reset_dut();
    repeat_en[0] = 1; noisy[0] = 1;
    for (int e = 1; e <= 32; e++) begin
      step();
      if (e == 13) noisy[0] = 0;
      checks++;
      if (dut_v() !== exp_v()) begin errors++; $display("FAIL race_model e=%0d got=%h exp=%h", e, dut_v(), exp_v()); end
      if (e == 19) begin
        checks++;
        if ({fall[0], press[0]} !== 2'b10) begin errors++; $display("FAIL race_edge got=%b exp=10", {fall[0], press[0]}); end
      end
      if (e > 19) begin
        checks++;
        if (press[0] !== 1'b0) begin errors++; $display("FAIL race_idle e=%0d got=%b exp=0", e, press[0]); end
      end
    end
  endtask
  task automatic test_reset_mid_repeat();
    reset_dut();
    repeat_en[0] = 1; noisy[0] = 1;
    for (int e = 1; e <= 30; e++) begin
      reset = (e == 17);
      step();
      checks++;
      if (dut_v() !== exp_v()) begin errors++; $display("FAIL reset_mid_model e=%0d got=%h exp=%h", e, dut_v(), exp_v()); end
      if (e >= 17 && e <= 23) begin
        checks++;
        if ({clean[0], rise[0], press[0]} !== ((e == 23) ? 3'b111 : 3'b000)) begin
          errors++; $display("FAIL reset_mid e=%0d got=%b", e, {clean[0], rise[0], press[0]});
        end
      end
    end
    reset = 0;
  endtask
  task automatic test_independence();
    reset_dut();
    noisy[0] = 1;
    for (int e = 1; e <= 12; e++) begin
      step();
      if (e == 2) noisy[1] = 1;
      checks++;
      if (dut_v() !== exp_v()) begin errors++; $display("FAIL indep_model e=%0d got=%h exp=%h", e, dut_v(), exp_v()); end
      checks++;
      if (rise !== ((e == 6) ? 2'b01 : (e == 8) ? 2'b10 : 2'b00)) begin errors++; $display("FAIL indep e=%0d got=%b", e, rise); end
    end
  endtask
  task automatic test_random();
    reset_dut();
    for (int n = 0; n < 4000; n++) begin
      reset = ($urandom_range(0, 499) == 0);
      for (int c = 0; c < 2; c++) begin
        if ($urandom_range(0, ((n / 200) % 2) ? 40 : 3) == 0) noisy[c] = ~noisy[c];
        if ($urandom_range(0, 60) == 0) repeat_en[c] = ~repeat_en[c];
      end
      step();
      checks++;
      if (dut_v() !== exp_v()) begin errors++; $display("FAIL random n=%0d got=%h exp=%h", n, dut_v(), exp_v()); end
    end
  endtask
  initial begin
    test_reset();
    test_clean_press();
    test_glitch();
    test_auto_repeat();
    test_release_race();
    test_reset_mid_repeat();
    test_independence();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
